// File: rtl/vga_box_ctrl_if.sv
// rtl/vga_box_ctrl_if.sv - box table configuration write port (valid/ready)
//
// Purpose : carries table writes from a register master into vga_box_ctrl.
// Signals : cfg_valid  write request
//           cfg_ready  write accepted when high together with cfg_valid
//           cfg_addr   {box index, field[2:0]}; AW = clog2(NBOX) + 3
//           cfg_data   16-bit write data
// Modports: master drives the request, slave (the controller) drives ready.

interface vga_box_ctrl_if #(
    parameter int AW = 5
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [AW-1:0] cfg_addr;
    logic [15:0]   cfg_data;

    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/vga_box_ctrl.sv
// rtl/vga_box_ctrl.sv - frame-synchronous rectangle overlay controller for VGA
//
// Purpose : holds NBOX coloured rectangles. Writes land in shadow registers
//           and the whole table is copied to the active set on the v_sync
//           active edge, so a frame never shows a half-updated table.
//           Pixels leave through a 2-stage pipeline; syncs are delayed to match.
// Ports   : clk, rst_n (async, active low)
//           xpos, ypos, h_sync_in, v_sync_in  from the timing generator
//           cfg (vga_box_ctrl_if.slave)        table write port
//           red, green, blue                   RGB565 pixel out
//           h_sync, v_sync                     syncs delayed 2 cycles
//           commit                             1-cycle pulse after a table copy
//           pending                            shadow holds uncommitted writes
// Option  : define VGA_BOX_OR_BLEND_EN to OR the colours of all hit boxes
//           instead of taking the lowest-index hit box.

module vga_box_ctrl #(
    parameter int   NBOX      = 4,
    parameter int   H_ACTIVE  = 640,
    parameter int   V_ACTIVE  = 480,
    parameter logic VS_ACTIVE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           xpos,
    input  logic [9:0]           ypos,
    input  logic                 h_sync_in,
    input  logic                 v_sync_in,
    vga_box_ctrl_if.slave        cfg,
    output logic [4:0]           red,
    output logic [5:0]           green,
    output logic [4:0]           blue,
    output logic                 h_sync,
    output logic                 v_sync,
    output logic                 commit,
    output logic                 pending
);

    localparam int LP_BW = $clog2(NBOX);
    localparam int LP_AW = LP_BW + 3;

    // 11-bit limits so a 10-bit position can be compared without overflow
    localparam logic [10:0] LP_HACT = 11'(H_ACTIVE);
    localparam logic [10:0] LP_VACT = 11'(V_ACTIVE);

    // ------------------------------------------------------------------
    // Shadow and active tables
    // ------------------------------------------------------------------
    logic [9:0]  r_sh_x0  [NBOX];
    logic [9:0]  r_sh_x1  [NBOX];
    logic [9:0]  r_sh_y0  [NBOX];
    logic [9:0]  r_sh_y1  [NBOX];
    logic [15:0] r_sh_col [NBOX];
    logic [NBOX-1:0] r_sh_en;

    logic [9:0]  r_ac_x0  [NBOX];
    logic [9:0]  r_ac_x1  [NBOX];
    logic [9:0]  r_ac_y0  [NBOX];
    logic [9:0]  r_ac_y1  [NBOX];
    logic [15:0] r_ac_col [NBOX];
    logic [NBOX-1:0] r_ac_en;

    logic              r_vs_prev;
    logic              r_commit;
    logic              r_pending;
    logic [NBOX-1:0]   r_hit;
    logic              r_vis;
    logic [15:0]       r_pix;
    logic [1:0]        r_hs_d;
    logic [1:0]        r_vs_d;

    logic              w_commit_now;
    logic              w_wr;
    logic [LP_BW-1:0]  w_box;
    logic [2:0]        w_field;
    logic [15:0]       w_pix;

    // ------------------------------------------------------------------
    // Commit detection and handshake
    // ------------------------------------------------------------------
    assign w_commit_now = (v_sync_in == VS_ACTIVE) && (r_vs_prev != VS_ACTIVE);

    // A write is held off during the copy cycle so shadow is never written
    // while it is being read into the active set; it lands one cycle later.
    assign cfg.cfg_ready = ~w_commit_now;
    assign w_wr          = cfg.cfg_valid & ~w_commit_now;
    assign w_box         = cfg.cfg_addr[LP_AW-1:3];
    assign w_field       = cfg.cfg_addr[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_prev <= ~VS_ACTIVE;
            r_commit  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_vs_prev <= v_sync_in;
            r_commit  <= w_commit_now;
            // Copy and write never share a cycle, so the order is free here.
            if (w_commit_now) begin
                r_pending <= 1'b0;
            end else if (w_wr && (w_field <= 3'd5)) begin
                r_pending <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow table writes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBOX; i++) begin
                r_sh_x0[i]  <= '0;
                r_sh_x1[i]  <= '0;
                r_sh_y0[i]  <= '0;
                r_sh_y1[i]  <= '0;
                r_sh_col[i] <= '0;
            end
            r_sh_en <= '0;
        end else if (w_wr) begin
            case (w_field)
                3'd0:    r_sh_x0[w_box]  <= cfg.cfg_data[9:0];
                3'd1:    r_sh_x1[w_box]  <= cfg.cfg_data[9:0];
                3'd2:    r_sh_y0[w_box]  <= cfg.cfg_data[9:0];
                3'd3:    r_sh_y1[w_box]  <= cfg.cfg_data[9:0];
                3'd4:    r_sh_col[w_box] <= cfg.cfg_data;
                3'd5:    r_sh_en[w_box]  <= cfg.cfg_data[0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Atomic copy shadow -> active on the v_sync active edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBOX; i++) begin
                r_ac_x0[i]  <= '0;
                r_ac_x1[i]  <= '0;
                r_ac_y0[i]  <= '0;
                r_ac_y1[i]  <= '0;
                r_ac_col[i] <= '0;
            end
            r_ac_en <= '0;
        end else if (w_commit_now) begin
            for (int i = 0; i < NBOX; i++) begin
                r_ac_x0[i]  <= r_sh_x0[i];
                r_ac_x1[i]  <= r_sh_x1[i];
                r_ac_y0[i]  <= r_sh_y0[i];
                r_ac_y1[i]  <= r_sh_y1[i];
                r_ac_col[i] <= r_sh_col[i];
            end
            r_ac_en <= r_sh_en;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: per-box hit test (strict bounds) and visible-area flag.
    // Strict bounds make a box with x0 >= x1-1 or y0 >= y1-1 empty.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit <= '0;
            r_vis <= 1'b0;
        end else begin
            for (int i = 0; i < NBOX; i++) begin
                r_hit[i] <= r_ac_en[i]
                          & (xpos > r_ac_x0[i]) & (xpos < r_ac_x1[i])
                          & (ypos > r_ac_y0[i]) & (ypos < r_ac_y1[i]);
            end
            r_vis <= ({1'b0, xpos} < LP_HACT) & ({1'b0, ypos} < LP_VACT);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: colour selection. Active colours are stable across the
    // visible area because the copy happens inside vertical sync.
    // ------------------------------------------------------------------
    always_comb begin
        w_pix = '0;
`ifdef VGA_BOX_OR_BLEND_EN
        for (int i = 0; i < NBOX; i++) begin
            if (r_hit[i]) begin
                w_pix = w_pix | r_ac_col[i];
            end
        end
`else
        // Walk from the top index down so the lowest hit index wins.
        for (int i = NBOX - 1; i >= 0; i--) begin
            if (r_hit[i]) begin
                w_pix = r_ac_col[i];
            end
        end
`endif
        if (!r_vis) begin
            w_pix = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix  <= '0;
            r_hs_d <= 2'b11;
            r_vs_d <= {2{~VS_ACTIVE}};
        end else begin
            r_pix  <= w_pix;
            r_hs_d <= {r_hs_d[0], h_sync_in};
            r_vs_d <= {r_vs_d[0], v_sync_in};
        end
    end

    assign red     = r_pix[15:11];
    assign green   = r_pix[10:5];
    assign blue    = r_pix[4:0];
    assign h_sync  = r_hs_d[1];
    assign v_sync  = r_vs_d[1];
    assign commit  = r_commit;
    assign pending = r_pending;

endmodule

// File: tb/tb_vga_box_ctrl.sv
// tb/tb_vga_box_ctrl.sv - directed self-checking bench for vga_box_ctrl

module tb_vga_box_ctrl;

    localparam int NBOX = 4;
    localparam int AW   = $clog2(NBOX) + 3;

`ifdef VGA_BOX_OR_BLEND_EN
    localparam logic [15:0] EXP_OVERLAP = 16'hFFE0;
`else
    localparam logic [15:0] EXP_OVERLAP = 16'hF800;
`endif

    logic       clk;
    logic       rst_n;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic       h_sync_in;
    logic       v_sync_in;
    logic [4:0] red;
    logic [5:0] green;
    logic [4:0] blue;
    logic       h_sync;
    logic       v_sync;
    logic       commit;
    logic       pending;
    logic [15:0] rgb;

    int checks = 0;
    int errors = 0;

    vga_box_ctrl_if #(.AW(AW)) cfg_if ();

    vga_box_ctrl #(
        .NBOX      (NBOX),
        .H_ACTIVE  (640),
        .V_ACTIVE  (480),
        .VS_ACTIVE (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .xpos      (xpos),
        .ypos      (ypos),
        .h_sync_in (h_sync_in),
        .v_sync_in (v_sync_in),
        .cfg       (cfg_if.slave),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .h_sync    (h_sync),
        .v_sync    (v_sync),
        .commit    (commit),
        .pending   (pending)
    );

    assign rgb = {red, green, blue};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int box, input int field, input logic [15:0] d);
        int n;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = AW'(box * 8 + field);
        cfg_if.cfg_data  = d;
        #1;
        n = 0;
        while (!cfg_if.cfg_ready && n < 4) begin
            tick();
            n++;
        end
        chk("wr_ready", 32'(cfg_if.cfg_ready), 32'd1);
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic write_box(input int box, input logic [9:0] x0, input logic [9:0] x1,
                             input logic [9:0] y0, input logic [9:0] y1,
                             input logic [15:0] col);
        cfg_write(box, 0, 16'(x0));
        cfg_write(box, 1, 16'(x1));
        cfg_write(box, 2, 16'(y0));
        cfg_write(box, 3, 16'(y1));
        cfg_write(box, 4, col);
        cfg_write(box, 5, 16'd1);
    endtask

    task automatic vs_pulse();
        v_sync_in = 1'b0;
        #1;
        chk("vs_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
        tick();
        chk("vs_commit_hi", 32'(commit), 32'd1);
        chk("vs_pending_clr", 32'(pending), 32'd0);
        tick();
        chk("vs_commit_lo", 32'(commit), 32'd0);
        v_sync_in = 1'b1;
        tick();
    endtask

    task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                         input logic [15:0] exp);
        xpos = x;
        ypos = y;
        tick();
        tick();
        chk(tag, 32'(rgb), 32'(exp));
    endtask

    initial begin
        rst_n            = 1'b1;
        xpos             = '0;
        ypos             = '0;
        h_sync_in        = 1'b1;
        v_sync_in        = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_addr  = '0;
        cfg_if.cfg_data  = '0;
        #2 rst_n = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_hsync", 32'(h_sync), 32'd1);
        chk("rst_vsync", 32'(v_sync), 32'd1);
        chk("rst_commit", 32'(commit), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 32'(cfg_if.cfg_ready), 32'd1);

        // empty table: black everywhere, one commit per active edge
        probe("blank_0_0", 10'd0, 10'd0, 16'h0000);
        probe("blank_mid", 10'd320, 10'd240, 16'h0000);
        probe("blank_end", 10'd639, 10'd479, 16'h0000);
        v_sync_in = 1'b0;
        tick();
        chk("long_vs_c1", 32'(commit), 32'd1);
        tick();
        chk("long_vs_c2", 32'(commit), 32'd0);
        tick();
        chk("long_vs_c3", 32'(commit), 32'd0);
        chk("long_vs_ready", 32'(cfg_if.cfg_ready), 32'd1);
        v_sync_in = 1'b1;
        tick();
        chk("blank_pending", 32'(pending), 32'd0);

        // box0 written mid-frame: not visible before commit
        write_box(0, 10'd50, 10'd90, 10'd50, 10'd90, 16'hF800);
        chk("b0_pending", 32'(pending), 32'd1);
        probe("b0_precommit", 10'd70, 10'd70, 16'h0000);
        vs_pulse();
        probe("b0_in", 10'd70, 10'd70, 16'hF800);
        probe("b0_x50", 10'd50, 10'd70, 16'h0000);
        probe("b0_x51", 10'd51, 10'd70, 16'hF800);
        probe("b0_x89", 10'd89, 10'd89, 16'hF800);
        probe("b0_x90", 10'd90, 10'd70, 16'h0000);
        probe("b0_y50", 10'd70, 10'd50, 16'h0000);
        probe("b0_y90", 10'd70, 10'd90, 16'h0000);

        // exact 2-cycle latency
        probe("lat_pre", 10'd10, 10'd10, 16'h0000);
        xpos = 10'd70;
        ypos = 10'd70;
        tick();
        chk("lat_1cyc", 32'(rgb), 32'h0000);
        tick();
        chk("lat_2cyc", 32'(rgb), 32'hF800);

        // write held across the commit cycle
        v_sync_in        = 1'b0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = AW'(1 * 8 + 0);
        cfg_if.cfg_data  = 16'd65;
        #1;
        chk("stall_ready0", 32'(cfg_if.cfg_ready), 32'd0);
        tick();
        chk("stall_commit", 32'(commit), 32'd1);
        chk("stall_pend0", 32'(pending), 32'd0);
        chk("stall_ready1", 32'(cfg_if.cfg_ready), 32'd1);
        tick();
        chk("stall_pend1", 32'(pending), 32'd1);
        chk("stall_commit0", 32'(commit), 32'd0);
        cfg_if.cfg_valid = 1'b0;
        v_sync_in        = 1'b1;
        tick();

        // overlapping box1, empty-ish box2, edge box3
        write_box(1, 10'd65, 10'd105, 10'd65, 10'd105, 16'h07E0);
        write_box(2, 10'd200, 10'd202, 10'd200, 10'd300, 16'h001F);
        write_box(3, 10'd600, 10'd700, 10'd10, 10'd100, 16'h1234);
        vs_pulse();
        probe("ovl_70_70", 10'd70, 10'd70, EXP_OVERLAP);
        probe("ovl_b1only", 10'd100, 10'd100, 16'h07E0);
        probe("ovl_b0only", 10'd60, 10'd60, 16'hF800);
        probe("thin_200", 10'd200, 10'd250, 16'h0000);
        probe("thin_201", 10'd201, 10'd250, 16'h001F);
        probe("thin_202", 10'd202, 10'd250, 16'h0000);
        probe("edge_600", 10'd600, 10'd50, 16'h0000);
        probe("edge_601", 10'd601, 10'd50, 16'h1234);
        probe("edge_639", 10'd639, 10'd50, 16'h1234);
        probe("edge_640", 10'd640, 10'd50, 16'h0000);
        probe("edge_650", 10'd650, 10'd50, 16'h0000);

        // sync delay
        h_sync_in = 1'b0;
        tick();
        chk("hs_d1", 32'(h_sync), 32'd1);
        tick();
        chk("hs_d2", 32'(h_sync), 32'd0);
        h_sync_in = 1'b1;
        v_sync_in = 1'b0;
        tick();
        chk("vs_d1", 32'(v_sync), 32'd1);
        tick();
        chk("vs_d2", 32'(v_sync), 32'd0);
        chk("hs_back", 32'(h_sync), 32'd1);
        v_sync_in = 1'b1;
        tick();
        tick();
        chk("vs_back", 32'(v_sync), 32'd1);

        // reserved field: accepted, no pending change
        cfg_write(0, 6, 16'hFFFF);
        chk("f6_pending", 32'(pending), 32'd0);

        // reset mid-frame
        probe("pre_rst", 10'd70, 10'd70, EXP_OVERLAP);
        cfg_write(0, 4, 16'h001F);
        chk("pre_rst_pend", 32'(pending), 32'd1);
        h_sync_in = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_rgb", 32'(rgb), 32'd0);
        chk("mrst_pending", 32'(pending), 32'd0);
        chk("mrst_commit", 32'(commit), 32'd0);
        chk("mrst_hsync", 32'(h_sync), 32'd1);
        h_sync_in = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        vs_pulse();
        probe("post_rst_b0", 10'd70, 10'd70, 16'h0000);
        probe("post_rst_b3", 10'd601, 10'd50, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
